// File: rtl/proc_control.sv
// proc_control
// Instruction-sequencing control unit for the simple processor. Accepts
// 16-bit instruction words over a valid/ready handshake and steps a small
// FSM. Each step drives the bus-source select, the A/G load strobes, the
// ALU add/sub select and the destination register index. The index feeds
// the downstream register-enable decoder in the same cycle.
//
// Ports
//   clk          system clock, rising edge
//   resetn       asynchronous, active-low reset
//   din          instruction word, or the immediate for mvi
//   din_valid    din holds a word this cycle
//   din_ready    block accepts din this cycle (transfer = valid & ready)
//   reg_num      destination index 0..7; 16'hFFFF means no write
//   bus_sel      bus source: 0..7 = R0..R7, 8 = DIN, 9 = G, 15 = none
//   a_load       load A from bus
//   g_load       load G from ALU (A +/- bus)
//   add_sub      0 = add, 1 = subtract
//   done         one-cycle pulse in the final cycle of an instruction
//   illegal      one-cycle pulse, coincident with done, for undefined opcodes
//   instr_count  count of retired instructions (legal and illegal), wraps
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for an instruction word; din_ready high
// EX1   | first execute step; mv/illegal retire, mvi waits for immediate,
//       | add/sub load A from rX
// EX2   | add/sub: G <= A +/- rY
// EX3   | add/sub: write G back to rX
module proc_control (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [15:0] reg_num,
  output logic [3:0]  bus_sel,
  output logic        a_load,
  output logic        g_load,
  output logic        add_sub,
  output logic        done,
  output logic        illegal,
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EX1  = 2'd1,
    S_EX2  = 2'd2,
    S_EX3  = 2'd3
  } state_t;

  localparam logic [2:0]  OP_MV   = 3'b000;
  localparam logic [2:0]  OP_MVI  = 3'b001;
  localparam logic [2:0]  OP_ADD  = 3'b010;
  localparam logic [2:0]  OP_SUB  = 3'b011;

  localparam logic [3:0]  BUS_DIN  = 4'd8;
  localparam logic [3:0]  BUS_G    = 4'd9;
  localparam logic [3:0]  BUS_NONE = 4'd15;
  localparam logic [15:0] NO_WRITE = 16'hFFFF;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] ir_q;
  logic [15:0] count_q;
  logic        load_ir;
  logic        ready_c;

  logic [2:0]  opcode;
  logic [2:0]  rx;
  logic [2:0]  ry;

  assign opcode = ir_q[15:13];
  assign rx     = ir_q[12:10];
  assign ry     = ir_q[9:7];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      ir_q    <= 16'h0000;
      count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (load_ir) begin
        ir_q <= din;
      end
      if (done) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    load_ir = 1'b0;
    ready_c = 1'b0;
    reg_num = NO_WRITE;
    bus_sel = BUS_NONE;
    a_load  = 1'b0;
    g_load  = 1'b0;
    add_sub = 1'b0;
    done    = 1'b0;
    illegal = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready_c = 1'b1;
        if (din_valid) begin
          load_ir = 1'b1;
          state_d = S_EX1;
        end
      end

      S_EX1: begin
        case (opcode)
          OP_MV: begin
            bus_sel = {1'b0, ry};
            reg_num = {13'b0, rx};
            done    = 1'b1;
            state_d = S_IDLE;
          end
          OP_MVI: begin
            // The immediate is consumed straight off the bus; the wait for
            // it has no timeout.
            ready_c = 1'b1;
            bus_sel = BUS_DIN;
            if (din_valid) begin
              reg_num = {13'b0, rx};
              done    = 1'b1;
              state_d = S_IDLE;
            end
          end
          OP_ADD, OP_SUB: begin
            bus_sel = {1'b0, rx};
            a_load  = 1'b1;
            state_d = S_EX2;
          end
          default: begin
            done    = 1'b1;
            illegal = 1'b1;
            state_d = S_IDLE;
          end
        endcase
      end

      S_EX2: begin
        bus_sel = {1'b0, ry};
        g_load  = 1'b1;
        // opcode bit 0 (IR[13]) separates add (010) from sub (011)
        add_sub = ir_q[13];
        state_d = S_EX3;
      end

      S_EX3: begin
        bus_sel = BUS_G;
        reg_num = {13'b0, rx};
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Upstream must see not-ready for the whole time reset is held, even
  // though the state register already sits in IDLE.
  assign din_ready   = ready_c & resetn;
  assign instr_count = count_q;

endmodule

// File: tb/tb_proc_control.sv
module tb_proc_control;

  logic        clk;
  logic        resetn;
  logic [15:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [15:0] reg_num;
  logic [3:0]  bus_sel;
  logic        a_load;
  logic        g_load;
  logic        add_sub;
  logic        done;
  logic        illegal;
  logic [15:0] instr_count;

  int checks;
  int errors;

  // {din_ready, bus_sel, reg_num, a_load, g_load, add_sub, done, illegal}
  logic [25:0] obs;
  assign obs = {din_ready, bus_sel, reg_num, a_load, g_load, add_sub, done, illegal};

  proc_control dut (
    .clk         (clk),
    .resetn      (resetn),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .reg_num     (reg_num),
    .bus_sel     (bus_sel),
    .a_load      (a_load),
    .g_load      (g_load),
    .add_sub     (add_sub),
    .done        (done),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit later,
  // i.e. the values the DUT presents to the following rising edge.

  task automatic test_reset();
    resetn    = 1'b0;
    din       = 16'h0000;
    din_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 1) din_valid = 1'b1;
      #1;
      checks++;
      if (obs !== {1'b0, 4'hF, 16'hFFFF, 5'b00000}) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got ready=%b bus=%h reg=%h strobes=%b, expected ready=0 bus=f reg=ffff strobes=00000",
                 i, din_ready, bus_sel, reg_num, obs[4:0]);
      end
      checks++;
      if (instr_count !== 16'h0000) begin
        errors++;
        $display("FAIL reset_count: got %h expected 0000", instr_count);
      end
    end
    @(negedge clk);
    din_valid = 1'b0;
    resetn    = 1'b1;
    #1;
    checks++;
    if (obs !== {1'b1, 4'hF, 16'hFFFF, 5'b00000}) begin
      errors++;
      $display("FAIL reset_release_idle: got ready=%b bus=%h reg=%h strobes=%b, expected ready=1 bus=f reg=ffff strobes=00000",
               din_ready, bus_sel, reg_num, obs[4:0]);
    end
    checks++;
    if (instr_count !== 16'h0000) begin
      errors++;
      $display("FAIL reset_release_count: got %h expected 0000", instr_count);
    end
  endtask

  task automatic test_mv();
    @(negedge clk);
    din       = 16'h0E80;  // mv r3,r5
    din_valid = 1'b1;
    #1;
    checks++;
    if (obs !== {1'b1, 4'hF, 16'hFFFF, 5'b00000}) begin
      errors++;
      $display("FAIL mv_accept: got obs=%h expected %h", obs, {1'b1, 4'hF, 16'hFFFF, 5'b00000});
    end
    @(negedge clk);
    din_valid = 1'b0;
    #1;
    checks++;
    if (obs !== {1'b0, 4'd5, 16'h0003, 5'b00010}) begin
      errors++;
      $display("FAIL mv_ex1: got ready=%b bus=%h reg=%h strobes=%b, expected ready=0 bus=5 reg=0003 strobes=00010",
               din_ready, bus_sel, reg_num, obs[4:0]);
    end
    @(negedge clk);
    #1;
    checks++;
    if (instr_count !== 16'h0001 || din_ready !== 1'b1) begin
      errors++;
      $display("FAIL mv_retire: got count=%h ready=%b, expected count=0001 ready=1", instr_count, din_ready);
    end
  endtask

  task automatic test_mvi();
    @(negedge clk);
    din       = 16'h3C00;  // mvi r7
    din_valid = 1'b1;
    #1;
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL mvi_accept_ready: got %b expected 1", din_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      din_valid = 1'b0;
      din       = 16'hDEAD;
      #1;
      checks++;
      if (obs !== {1'b1, 4'd8, 16'hFFFF, 5'b00000}) begin
        errors++;
        $display("FAIL mvi_wait cycle %0d: got ready=%b bus=%h reg=%h strobes=%b, expected ready=1 bus=8 reg=ffff strobes=00000",
                 i, din_ready, bus_sel, reg_num, obs[4:0]);
      end
    end
    @(negedge clk);
    din       = 16'h1234;
    din_valid = 1'b1;
    #1;
    checks++;
    if (obs !== {1'b1, 4'd8, 16'h0007, 5'b00010}) begin
      errors++;
      $display("FAIL mvi_imm: got ready=%b bus=%h reg=%h strobes=%b, expected ready=1 bus=8 reg=0007 strobes=00010",
               din_ready, bus_sel, reg_num, obs[4:0]);
    end
    @(negedge clk);
    din_valid = 1'b0;
    #1;
    checks++;
    if (instr_count !== 16'h0002 || obs !== {1'b1, 4'hF, 16'hFFFF, 5'b00000}) begin
      errors++;
      $display("FAIL mvi_retire: got count=%h obs=%h, expected count=0002 obs=%h",
               instr_count, obs, {1'b1, 4'hF, 16'hFFFF, 5'b00000});
    end
  endtask

  task automatic test_sub();
    logic [25:0] exp_seq [3];
    exp_seq[0] = {1'b0, 4'd1, 16'hFFFF, 5'b10000};
    exp_seq[1] = {1'b0, 4'd2, 16'hFFFF, 5'b01100};
    exp_seq[2] = {1'b0, 4'd9, 16'h0001, 5'b00010};
    @(negedge clk);
    din       = 16'h6500;  // sub r1,r2
    din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      // keep offering words; none may be consumed
      din = 16'h0E80;
      #1;
      checks++;
      if (obs !== exp_seq[i]) begin
        errors++;
        $display("FAIL sub_ex%0d: got ready=%b bus=%h reg=%h strobes=%b, expected ready=%b bus=%h reg=%h strobes=%b",
                 i + 1, din_ready, bus_sel, reg_num, obs[4:0],
                 exp_seq[i][25], exp_seq[i][24:21], exp_seq[i][20:5], exp_seq[i][4:0]);
      end
    end
    @(negedge clk);
    din_valid = 1'b0;
    #1;
    checks++;
    if (instr_count !== 16'h0003 || din_ready !== 1'b1) begin
      errors++;
      $display("FAIL sub_retire: got count=%h ready=%b, expected count=0003 ready=1", instr_count, din_ready);
    end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    din       = 16'hE000;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    #1;
    checks++;
    if (obs !== {1'b0, 4'hF, 16'hFFFF, 5'b00011}) begin
      errors++;
      $display("FAIL illegal_ex1: got ready=%b bus=%h reg=%h strobes=%b, expected ready=0 bus=f reg=ffff strobes=00011",
               din_ready, bus_sel, reg_num, obs[4:0]);
    end
    @(negedge clk);
    #1;
    checks++;
    if (instr_count !== 16'h0004) begin
      errors++;
      $display("FAIL illegal_count: got %h expected 0004", instr_count);
    end
  endtask

  task automatic test_back_to_back();
    // valid held high: mv r3,r5 then mv r6,r1; second word offered during
    // the first instruction's done cycle must wait for IDLE.
    @(negedge clk);
    din       = 16'h0E80;
    din_valid = 1'b1;
    @(negedge clk);
    din = 16'h1880;
    #1;
    checks++;
    if (obs !== {1'b0, 4'd5, 16'h0003, 5'b00010}) begin
      errors++;
      $display("FAIL b2b_first_done: got obs=%h expected %h", obs, {1'b0, 4'd5, 16'h0003, 5'b00010});
    end
    @(negedge clk);
    #1;
    checks++;
    if (obs !== {1'b1, 4'hF, 16'hFFFF, 5'b00000}) begin
      errors++;
      $display("FAIL b2b_idle_gap: got obs=%h expected %h", obs, {1'b1, 4'hF, 16'hFFFF, 5'b00000});
    end
    @(negedge clk);
    din_valid = 1'b0;
    #1;
    checks++;
    if (obs !== {1'b0, 4'd1, 16'h0006, 5'b00010}) begin
      errors++;
      $display("FAIL b2b_second_done: got obs=%h expected %h", obs, {1'b0, 4'd1, 16'h0006, 5'b00010});
    end
    @(negedge clk);
    #1;
    checks++;
    if (instr_count !== 16'h0006) begin
      errors++;
      $display("FAIL b2b_count: got %h expected 0006", instr_count);
    end
  endtask

  task automatic test_abort();
    @(negedge clk);
    din       = 16'h4980;  // add r2,r3
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    #1;
    checks++;
    if (obs !== {1'b0, 4'd2, 16'hFFFF, 5'b10000}) begin
      errors++;
      $display("FAIL abort_add_ex1: got obs=%h expected %h", obs, {1'b0, 4'd2, 16'hFFFF, 5'b10000});
    end
    @(negedge clk);
    #1;
    checks++;
    if (obs !== {1'b0, 4'd3, 16'hFFFF, 5'b01000}) begin
      errors++;
      $display("FAIL abort_add_ex2: got obs=%h expected %h", obs, {1'b0, 4'd3, 16'hFFFF, 5'b01000});
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (obs !== {1'b0, 4'hF, 16'hFFFF, 5'b00000} || instr_count !== 16'h0000) begin
      errors++;
      $display("FAIL abort_in_reset: got obs=%h count=%h, expected obs=%h count=0000",
               obs, instr_count, {1'b0, 4'hF, 16'hFFFF, 5'b00000});
    end
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs !== {1'b1, 4'hF, 16'hFFFF, 5'b00000} || instr_count !== 16'h0000) begin
        errors++;
        $display("FAIL abort_after cycle %0d: got obs=%h count=%h, expected obs=%h count=0000",
                 i, obs, instr_count, {1'b1, 4'hF, 16'hFFFF, 5'b00000});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    // Preload the retire counter near the top so the wrap is reached in a
    // few instructions instead of 65536.
    @(negedge clk);
    force dut.count_q = 16'hFFFE;
    #1;
    release dut.count_q;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      din       = 16'h0080;  // mv r0,r1
      din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
      #1;
      checks++;
      if (obs !== {1'b0, 4'd1, 16'h0000, 5'b00010}) begin
        errors++;
        $display("FAIL wrap_mv_done %0d: got obs=%h expected %h", i, obs, {1'b0, 4'd1, 16'h0000, 5'b00010});
      end
      @(negedge clk);
      #1;
      checks++;
      if (instr_count !== ((i == 0) ? 16'hFFFF : 16'h0000)) begin
        errors++;
        $display("FAIL wrap_count %0d: got %h expected %h", i, instr_count,
                 (i == 0) ? 16'hFFFF : 16'h0000);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mv();
    test_mvi();
    test_sub();
    test_illegal();
    test_back_to_back();
    test_abort();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
